// File: rtl/riscv_mem_pkg.sv
// Shared types for the unified memory port arbiter.
// Arbiter states, port ownership and default widths.
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        RESP
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    // bits needed to hold the value n
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on the memory port.
// timeout rises on the TIMEOUT-th enabled cycle.
module mem_wait_timer
    import riscv_mem_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int W = cnt_w(TIMEOUT);

    logic [W-1:0] cnt;

    assign timeout = enable && (cnt == W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !timeout) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch / load-store arbiter onto one memory port.
// Optional stall counters under MEM_ARB_PERF_EN.
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int TIMEOUT  = 15,
    parameter int D_STARVE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_if_stall,
    output logic [31:0]       perf_d_stall
`endif
);

    localparam int SW = cnt_w(D_STARVE);

    arb_state_t    state;
    owner_t        owner;
    logic [SW-1:0] starve;
    logic          busy;
    logic          tmo;
    logic          fetch_due;

    assign busy      = (state == BUSY_I) || (state == BUSY_D);
    assign fetch_due = if_req && (starve == SW'(D_STARVE));

    mem_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!busy),
        .enable (busy && !mem_ready),
        .timeout(tmo)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            starve    <= '0;
            if_gnt    <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_gnt     <= 1'b0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            bus_err   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_rvalid <= 1'b0;
            d_rvalid  <= 1'b0;
            bus_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (d_req && !fetch_due) begin
                        d_gnt     <= 1'b1;
                        owner     <= OWN_D;
                        state     <= BUSY_D;
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        starve    <= if_req ? starve + SW'(1) : '0;
                    end else if (if_req) begin
                        if_gnt    <= 1'b1;
                        owner     <= OWN_I;
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        starve    <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // ready wins over a timeout in the same cycle
                    if (mem_ready || tmo) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= !mem_ready;
                        state   <= RESP;
                        if (owner == OWN_D) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_ready ? mem_rdata : '0;
                        end else begin
                            if_rvalid <= 1'b1;
                            if_rdata  <= mem_ready ? mem_rdata : '0;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_if_stall <= '0;
            perf_d_stall  <= '0;
        end else begin
            if (if_req && !if_rvalid && perf_if_stall != '1) begin
                perf_if_stall <= perf_if_stall + 32'd1;
            end
            if (d_req && !d_rvalid && perf_d_stall != '1) begin
                perf_d_stall <= perf_d_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, requester agents,
// memory model and a scoreboard of expected grants/responses.
module tb_mem_port_arbiter;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;
    } vec_t;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_stall;
    logic [31:0] perf_d_stall;
`endif

    exp_t sb[$];
    req_t iq[$];
    req_t dq[$];
    int   errors = 0;
    int   checks = 0;
    int   mem_delay = 1;
    int   wcnt = 0;
    bit   kill = 1'b0;
    logic ready_q = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (15),
        .D_STARVE(4)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .bus_err  (bus_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
`ifdef MEM_ARB_PERF_EN
        ,
        .perf_if_stall(perf_if_stall),
        .perf_d_stall (perf_d_stall)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act,
                        input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // expected value comes from the memory model: rdata = addr + 0x13
    task automatic issue(input bit is_d, input bit we,
                         input logic [31:0] addr,
                         input logic [31:0] wdata, input bit err);
        exp_t e;
        req_t r;
        e = '{is_d, we, addr, wdata, err ? 32'h0 : addr + 32'h13, err};
        r = '{we, addr, wdata};
        sb.push_back(e);
        if (is_d) dq.push_back(r);
        else iq.push_back(r);
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while ((sb.size() > 0 || if_req || d_req ||
                iq.size() > 0 || dq.size() > 0) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= maxc) begin
            errors++;
            $display("FAIL wait_done: %0d pending after %0d cycles, want 0",
                     sb.size(), n);
            sb.delete();
        end
    endtask

    // memory: mem_ready after mem_delay cycles of mem_req (0 = never)
    initial begin
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!mem_req) begin
                wcnt      = 0;
                mem_ready = 1'b0;
            end else begin
                wcnt++;
                mem_ready = (mem_delay != 0) && (wcnt == mem_delay);
            end
            mem_rdata = mem_addr + 32'h13;
        end
    end

    initial forever begin
        @(posedge clk);
        ready_q <= mem_ready;
    end

    // requester agents: hold req until rvalid, chain queued requests
    initial begin
        req_t r;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        forever begin
            @(negedge clk);
            if (kill) begin
                if_req = 1'b0;
                d_req  = 1'b0;
                iq.delete();
                dq.delete();
            end else begin
                if (if_req && if_rvalid && iq.size() == 0) begin
                    if_req = 1'b0;
                end else if ((if_req && if_rvalid) ||
                             (!if_req && iq.size() > 0)) begin
                    r       = iq.pop_front();
                    if_addr = r.addr;
                    if_req  = 1'b1;
                end
                if (d_req && d_rvalid && dq.size() == 0) begin
                    d_req = 1'b0;
                end else if ((d_req && d_rvalid) ||
                             (!d_req && dq.size() > 0)) begin
                    r       = dq.pop_front();
                    d_we    = r.we;
                    d_addr  = r.addr;
                    d_wdata = r.wdata;
                    d_req   = 1'b1;
                end
            end
        end
    end

    // scoreboard monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && (if_gnt || d_gnt)) begin
                chk1("single_gnt", if_gnt & d_gnt, 1'b0);
                chk1("gnt_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb[0];
                    chk1("gnt_port", d_gnt, e.is_d);
                    chk1("gnt_mem_req", mem_req, 1'b1);
                    chk1("gnt_mem_we", mem_we, e.we);
                    chk("gnt_mem_addr", mem_addr, e.addr);
                    if (e.we) chk("gnt_mem_wdata", mem_wdata, e.wdata);
                end
            end
            if (!rst && (if_rvalid || d_rvalid)) begin
                chk1("single_rvalid", if_rvalid & d_rvalid, 1'b0);
                chk1("rvalid_expected", sb.size() > 0, 1'b1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk1("rv_port", d_rvalid, e.is_d);
                    chk("rv_rdata", d_rvalid ? d_rdata : if_rdata, e.rdata);
                    chk1("rv_bus_err", bus_err, e.err);
                    if (!e.err) chk1("rv_latency", ready_q, 1'b1);
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   n;
        bit   er;
        rst = 1'b1;
        vt[0] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0, 2};
        vt[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0, 1};
        vt[2] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 3};
        vt[3] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0, 1};
        vt[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'h0, 15};
        vt[5] = '{1'b1, 1'b1, 32'h0000_0400, 32'h1234_5678, 0};

        repeat (2) @(negedge clk);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_if_gnt", if_gnt, 1'b0);
        chk1("rst_d_gnt", d_gnt, 1'b0);
        chk1("rst_if_rvalid", if_rvalid, 1'b0);
        chk1("rst_d_rvalid", d_rvalid, 1'b0);
        chk1("rst_bus_err", bus_err, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        chk("rst_d_rdata", d_rdata, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
`ifdef MEM_ARB_PERF_EN
        chk("rst_perf_if", perf_if_stall, 32'h0);
        chk("rst_perf_d", perf_d_stall, 32'h0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            sync();
            mem_delay = vt[i].delay;
            er = (vt[i].delay == 0) || (vt[i].delay > 15);
            issue(vt[i].is_d, vt[i].we, vt[i].addr, vt[i].wdata, er);
            wait_done(60);
        end

        // simultaneous requests: data first, then fetch
        sync();
        mem_delay = 1;
        issue(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
        wait_done(60);

        // starvation: 4 data grants, fetch, 4 more, fetch
        sync();
        for (int k = 0; k < 4; k++)
            issue(1'b1, 1'b0, 32'h1000 + 32'(4 * k), 32'h0, 1'b0);
        issue(1'b0, 1'b0, 32'h2000, 32'h0, 1'b0);
        for (int k = 4; k < 8; k++)
            issue(1'b1, 1'b1, 32'h1000 + 32'(4 * k), 32'(k), 1'b0);
        issue(1'b0, 1'b0, 32'h2004, 32'h0, 1'b0);
        wait_done(200);

        // timeout: mem_req held exactly 15 cycles
        sync();
        mem_delay = 0;
        issue(1'b0, 1'b0, 32'h80, 32'h0, 1'b1);
        n = 0;
        while (!mem_req && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (mem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk("timeout_cycles", 32'(n), 32'd15);
        chk1("timeout_rvalid", if_rvalid, 1'b1);
        wait_done(60);

        // reset while a data access is waiting
        sync();
        mem_delay = 0;
        issue(1'b1, 1'b0, 32'h500, 32'h0, 1'b0);
        n = 0;
        while (!d_gnt && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk1("busy_d_gnt", d_gnt, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk1("async_mem_req", mem_req, 1'b0);
        chk1("async_d_rvalid", d_rvalid, 1'b0);
        kill = 1'b1;
        repeat (2) @(negedge clk);
        sb.delete();
        kill = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk1("post_rst_no_rvalid", d_rvalid, 1'b0);
        sync();
        mem_delay = 1;
        issue(1'b0, 1'b0, 32'h600, 32'h0, 1'b0);
        wait_done(60);

`ifdef MEM_ARB_PERF_EN
        sync();
        rst = 1'b1;
        #2;
        chk("perf_if_clr", perf_if_stall, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        mem_delay = 9;
        issue(1'b0, 1'b0, 32'h700, 32'h0, 1'b0);
        wait_done(60);
        chk("perf_if_stall", perf_if_stall, 32'd10);
        chk("perf_d_stall", perf_d_stall, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
